// File: rtl/bumpy_pkg.sv
// Shared definitions for the bumpy sprite collision detector: edge bit
// positions in the 4-bit edge code, default geometry and FSM state type.
package bumpy_pkg;

    // Bit positions inside the {Left, Top, Right, Bottom} edge code
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    localparam int SPRITE_SIZE_DEF = 32;
    localparam int EDGE_W_DEF      = 4;
    localparam int COOLDOWN_DEF    = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } state_t;

endpackage

// File: rtl/bumpy_edge_classify.sv
// Combinational edge classifier: maps a colliding pixel's offset inside the
// sprite to the set of edge bands it lies in. Corners set two bits, interior
// pixels set none, and nothing is set when there is no hit.
module bumpy_edge_classify
    import bumpy_pkg::*;
#(
    parameter int SPRITE_SIZE = SPRITE_SIZE_DEF,
    parameter int EDGE_W      = EDGE_W_DEF
) (
    input  logic        i_hit,
    input  logic [10:0] i_offsetX,
    input  logic [10:0] i_offsetY,
    output logic [3:0]  o_edges
);

    localparam logic [10:0] LO_LIM = 11'(EDGE_W);
    localparam logic [10:0] HI_LIM = 11'(SPRITE_SIZE - EDGE_W);

    // Classify the pixel into edge bands, gated by the pixel hit
    always_comb begin
        o_edges = '0;
        if (i_hit) begin
            o_edges[EDGE_LEFT]   = (i_offsetX <  LO_LIM);
            o_edges[EDGE_RIGHT]  = (i_offsetX >= HI_LIM);
            o_edges[EDGE_TOP]    = (i_offsetY <  LO_LIM);
            o_edges[EDGE_BOTTOM] = (i_offsetY >= HI_LIM);
        end
    end

endmodule

// File: rtl/bumpy_collision.sv
// Bumpy sprite collision detector. Accumulates the edges touched during a
// frame, and in the cycle after each frame boundary reports them with a single
// pulse, subject to a cooldown of a few frames after every pulse.
module bumpy_collision
    import bumpy_pkg::*;
#(
    parameter int SPRITE_SIZE     = SPRITE_SIZE_DEF,
    parameter int EDGE_W          = EDGE_W_DEF,
    parameter int COOLDOWN_FRAMES = COOLDOWN_DEF
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        bumpyDR,
    input  logic [10:0] offsetX,
    input  logic [10:0] offsetY,
    input  logic        stepDR,
    input  logic        borderDR,
    output logic        singleHitPulse,
    output logic [3:0]  HitEdgeCode,
    output logic [7:0]  hitCount
);

    localparam int              CW        = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0]   COOL_LOAD = CW'(COOLDOWN_FRAMES);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_acc;
    logic [3:0]    r_pend;
    logic [3:0]    r_code;
    logic [7:0]    r_cnt;
    logic [CW-1:0] r_cool;

    logic          w_hit;
    logic [3:0]    w_edges;
    logic          w_pulse;
    logic          w_keep_pend;
    logic [7:0]    w_cnt_inc;

    assign w_hit = bumpyDR & (stepDR | borderDR);

    bumpy_edge_classify #(
        .SPRITE_SIZE (SPRITE_SIZE),
        .EDGE_W      (EDGE_W)
    ) u_classify (
        .i_hit     (w_hit),
        .i_offsetX (offsetX),
        .i_offsetY (offsetY),
        .o_edges   (w_edges)
    );

    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // A frame closing while cooldown is running (or in the very cycle a pulse
    // fires, which reloads it) is dropped at capture time.
    assign w_keep_pend = w_pulse ? (COOL_LOAD == '0) : (r_cool == '0);

    // Next state and pulse decision; a reset in the EVAL cycle suppresses it
    always_comb begin
        w_state_nxt = r_state;
        w_pulse     = 1'b0;
        case (r_state)
            ST_IDLE: if (startOfFrame) w_state_nxt = ST_EVAL;
            ST_EVAL: begin
                w_pulse     = (r_pend != 4'd0) && (r_cool == '0) && !resetN;
                w_state_nxt = startOfFrame ? ST_EVAL : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs reflect a pulse in the same cycle it fires, then hold
    assign singleHitPulse = w_pulse;
    assign HitEdgeCode    = w_pulse ? r_pend : r_code;
    assign hitCount       = w_pulse ? w_cnt_inc : r_cnt;

    // State, frame accumulator, pending capture, cooldown and hit history
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_pend  <= '0;
            r_code  <= '0;
            r_cnt   <= '0;
            r_cool  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (startOfFrame) begin
                r_acc  <= w_edges;
                r_pend <= w_keep_pend ? r_acc : 4'd0;
            end else begin
                r_acc  <= r_acc | w_edges;
            end
            if (w_pulse)
                r_cool <= COOL_LOAD;
            else if (startOfFrame && (r_cool != '0))
                r_cool <= r_cool - CW'(1);
            if (w_pulse) begin
                r_code <= r_pend;
                r_cnt  <= w_cnt_inc;
            end
        end
    end

endmodule

// File: doc/bumpy_collision.md
BUMPY_COLLISION -- requirements
Module: bumpy_collision

Interface
REQ-001 Parameter SPRITE_SIZE, default 32, meaning bumpy sprite width and height in pixels.
REQ-002 Parameter EDGE_W, default 4, meaning depth in pixels of each edge band used for classification.
REQ-003 Parameter COOLDOWN_FRAMES, default 2, meaning number of frames after a pulse in which new pulses are suppressed.
REQ-004 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 resetN  input  1  reset, synchronous and active-high (asserted = 1).
REQ-006 startOfFrame  input  1  one-cycle pulse at start of each frame.
REQ-007 bumpyDR  input  1  bumpy sprite drawing request at the current pixel.
REQ-008 offsetX  input  11  current pixel X offset inside bumpy sprite, valid when bumpyDR=1.
REQ-009 offsetY  input  11  current pixel Y offset inside bumpy sprite, valid when bumpyDR=1.
REQ-010 stepDR  input  1  step/brick drawing request at the current pixel.
REQ-011 borderDR  input  1  frame border drawing request at the current pixel.
REQ-012 singleHitPulse  output  1  one-cycle pulse reporting a collision in the previous frame.
REQ-013 HitEdgeCode  output  4  {Left, Top, Right, Bottom} edges hit in the previous frame.
REQ-014 hitCount  output  8  saturating count of issued pulses since reset.

Function
REQ-015 Pixel hit SHALL be bumpyDR AND (stepDR OR borderDR), evaluated each cycle.
REQ-016 On a pixel hit, bits SHALL set combinationally: Left if offsetX < EDGE_W; Right if offsetX >= SPRITE_SIZE-EDGE_W; Top if offsetY < EDGE_W; Bottom if offsetY >= SPRITE_SIZE-EDGE_W; a corner sets two bits, an interior pixel sets none.
REQ-017 Frame accumulator (4 bits) SHALL OR in classified bits on every pixel-hit cycle where startOfFrame=0.
REQ-018 On startOfFrame=1: accumulator SHALL be captured into a pending register and cleared to 0 in the same edge; a pixel hit in that same cycle SHALL load into the cleared accumulator (belongs to new frame).
REQ-019 Cycle after startOfFrame: if pending != 0 and cooldown counter = 0, singleHitPulse SHALL be 1 for exactly one cycle, HitEdgeCode SHALL equal pending in that same cycle.
REQ-020 HitEdgeCode SHALL hold its value until the next pulse; it SHALL be 0 after reset.
REQ-021 Accumulated pending with all bits 0 (interior-only or no hit) SHALL produce no pulse and leave HitEdgeCode unchanged.
REQ-022 Cooldown counter SHALL load COOLDOWN_FRAMES on a pulse and decrement by 1 on each subsequent startOfFrame while nonzero; pending captured while counter nonzero SHALL be discarded.
REQ-023 Pending data SHALL be evaluated only in the cycle after startOfFrame; back-to-back startOfFrame pulses SHALL each be treated as a frame boundary.
REQ-024 hitCount SHALL increment on each pulse and saturate at 255.
REQ-025 State machine: IDLE (wait startOfFrame) -> EVAL (one cycle, decide pulse) -> IDLE; no other states.

Reset
REQ-026 While resetN=1 at a clock edge: singleHitPulse=0, HitEdgeCode=0, hitCount=0, accumulator=0, pending=0, cooldown=0, state=IDLE.
REQ-027 Reset asserted during EVAL SHALL abort it with no pulse; first frame after release SHALL not pulse (accumulator empty).

Structure
REQ-028 Shared package bumpy_pkg SHALL hold edge bit indices (LEFT=3, TOP=2, RIGHT=1, BOTTOM=0), SPRITE_SIZE default, and state enum type.
REQ-029 One combinational sub-module bumpy_edge_classify SHALL implement REQ-016; all state in bumpy_collision.

Verification
REQ-030 Frame with one hit at offset (0,10) with stepDR, then startOfFrame -> next cycle singleHitPulse=1, HitEdgeCode=4'b1000, hitCount=1.
REQ-031 Hit at offset (31,31) with borderDR -> HitEdgeCode=4'b0011 with a single one-cycle pulse.
REQ-032 Hits on three consecutive frames, COOLDOWN_FRAMES=2 -> pulse on frame 1 only, frame 4 hit pulses again.
REQ-033 Hit at offset (16,16) only -> no pulse, HitEdgeCode keeps previous value.
REQ-034 Hit coincident with startOfFrame at offset (0,0) -> no pulse for closing frame; next boundary pulses 4'b1100.
REQ-035 resetN=1 during EVAL cycle with pending 4'b0001 -> no pulse, all outputs 0 next cycle.
